// File: rtl/cla_add_sequencer.sv
// Shared 4-bit carry-look-ahead adder sequenced nibble-by-nibble
// between two round-robin arbitrated requesters.
module carry_look_ahead_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g, p;
   logic c1, c2, c3;

   assign g = a & b;
   assign p = a ^ b;

   assign c1 = g[0] | (p[0] & cin);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ {c3, c2, c1, cin};
endmodule

module cla_add_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t               state;
   logic [NIB-1:0][3:0]  a_r, b_r, sum_r;
   logic [IW-1:0]        nib_idx;
   logic                 carry;
   logic                 last_grant;
   logic                 id_r;
   logic                 grant0, grant1;
   logic                 hs0, hs1;
   logic [3:0]           s;
   logic                 co;

   // On a tie the requester not served last wins.
   assign grant0 = req0_valid && (!req1_valid || last_grant);
   assign grant1 = req1_valid && (!req0_valid || !last_grant);

   assign req0_ready = !rst && (state == IDLE) && grant0;
   assign req1_ready = !rst && (state == IDLE) && grant1;

   assign hs0 = req0_valid && req0_ready;
   assign hs1 = req1_valid && req1_ready;

   carry_look_ahead_adder u_cla (
      .a    (a_r[nib_idx]),
      .b    (b_r[nib_idx]),
      .cin  (carry),
      .s    (s),
      .cout (co)
   );

   assign res_sum  = sum_r;
   assign res_cout = carry;
   assign res_id   = id_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         res_valid  <= 1'b0;
         a_r        <= '0;
         b_r        <= '0;
         sum_r      <= '0;
         nib_idx    <= '0;
         carry      <= 1'b0;
         id_r       <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (hs0 || hs1) begin
                  a_r        <= hs1 ? req1_a : req0_a;
                  b_r        <= hs1 ? req1_b : req0_b;
                  carry      <= hs1 ? req1_cin : req0_cin;
                  id_r       <= hs1;
                  last_grant <= hs1;
                  nib_idx    <= '0;
                  state      <= ADD;
               end
            end
            ADD: begin
               sum_r[nib_idx] <= s;
               carry          <= co;
               if (nib_idx == IW'(NIB - 1)) begin
                  nib_idx   <= '0;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  nib_idx <= nib_idx + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
